bpred_gshare: RTL and testbench
===============================

BPRED_GSHARE -- requirements
Module: bpred_gshare

Interface
REQ-001 SHALL have parameter IDX_W, default 8: table index width; table depth is 2^IDX_W entries.
REQ-002 SHALL have parameter HIST_W, default 8: global history width; legal range 1..IDX_W.
REQ-003 SHALL have parameter CTR_W, default 2: saturating counter width; legal range 2..4.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1 bit: freezes lookup, update, GHR and stats.
REQ-007 SHALL have port lookup_valid, input, 1 bit: lookup request this cycle.
REQ-008 SHALL have port lookup_pc, input, 32 bits: fetch PC of the branch to predict.
REQ-009 SHALL have port pred_valid, output, 1 bit: prediction outputs valid.
REQ-010 SHALL have port pred_dir, output, 1 bit: predicted taken.
REQ-011 SHALL have port pred_idx, output, IDX_W bits: table index used, carried down the pipe.
REQ-012 SHALL have port pred_ctr, output, CTR_W bits: counter value read, carried down the pipe.
REQ-013 SHALL have port pred_hist, output, HIST_W bits: GHR value used for the index, carried down the pipe.
REQ-014 SHALL have port update_valid, input, 1 bit: resolved branch from execute.
REQ-015 SHALL have ports update_idx (IDX_W), update_ctr (CTR_W), update_hist (HIST_W), inputs: values returned from pred_idx, pred_ctr, pred_hist.
REQ-016 SHALL have port update_dir, input, 1 bit: actual branch direction.
REQ-017 SHALL have port update_miss, input, 1 bit: branch was mispredicted.
REQ-018 SHALL have port init_busy, output, 1 bit: table initialisation in progress.
REQ-019 SHALL have port debug_sel, input, 2 bits: statistics select.
REQ-020 SHALL have port debug_out, output, 32 bits: selected statistic.

Function
REQ-021 SHALL hold a table of 2^IDX_W counters, each CTR_W bits wide, with one read port and one write port.
REQ-022 SHALL form the lookup index as lookup_pc[IDX_W+1:2] XOR {zeros, GHR}.
REQ-023 SHALL implement a two-state FSM, INIT then READY; reset enters INIT with the sweep pointer at 0.
REQ-024 In INIT, SHALL write weakly-not-taken, value 2^(CTR_W-1)-1, to entry ptr once per cycle, regardless of stall.
REQ-025 In INIT, SHALL increment ptr each cycle and move to READY in the cycle after writing entry 2^IDX_W-1.
REQ-026 In INIT, init_busy SHALL be 1, pred_valid SHALL be 0, and lookups and updates SHALL be ignored.
REQ-027 SHALL assert reset in any state, including mid-sweep, to restart the sweep from entry 0.
REQ-028 Lookup latency SHALL be 1 cycle: lookup_valid & ~stall in READY at cycle N gives pred_valid=1 with its data at cycle N+1.
REQ-029 SHALL drive pred_dir equal to the MSB of the counter read.
REQ-030 When a lookup is not accepted, SHALL set pred_valid to 0 and hold pred_idx, pred_ctr, pred_hist and pred_dir.
REQ-031 SHALL apply the speculative GHR update in every cycle with pred_valid=1 and stall=0: GHR <= {GHR[HIST_W-2:0], pred_dir}; for HIST_W=1, GHR <= pred_dir.
REQ-032 SHALL repair the GHR on update_valid & update_miss & ~stall in READY: GHR <= {update_hist[HIST_W-2:0], update_dir}.
REQ-033 Repair SHALL take priority over a same-cycle speculative shift.
REQ-034 On update_valid & ~stall in READY, SHALL write table[update_idx] with the saturating update of update_ctr: +1 if update_dir, -1 otherwise, clamped to 0 and 2^CTR_W-1.
REQ-035 On a same-cycle read and write of the same index, the read SHALL return the old value, with no bypass.
REQ-036 SHALL keep 32-bit wrapping statistics, advanced only in READY with stall=0:
  - lookups: +1 per accepted lookup
  - updates: +1 per update_valid
  - misses: +1 per update_valid & update_miss
  - repairs: +1 per GHR repair
REQ-037 SHALL drive debug_out combinationally from debug_sel: 00 lookups, 01 updates, 10 misses, 11 repairs.

Reset
REQ-038 On reset, SHALL clear GHR, all statistics, pred_valid, pred_dir, pred_idx, pred_ctr and pred_hist to 0.
REQ-039 On reset, SHALL set init_busy to 1 in the following cycle and keep it at 1 for exactly 2^IDX_W cycles after reset deasserts.

Verification
REQ-040 SHALL verify init: with IDX_W=8, deassert reset, then lookup pc=0x0 at the first cycle init_busy=0 -> init_busy is high for 256 cycles; next cycle pred_valid=1, pred_ctr=01, pred_dir=0.
REQ-041 SHALL verify saturation and GHR: repeat pc=0x40 with taken updates using the returned idx, ctr and hist -> counter goes 01, 10, 11, 11 and GHR shifts in 1s.
REQ-042 SHALL verify repair: GHR=0xA5, lookup predicts taken, then update_miss=1, update_dir=0, update_hist=0x52 arrives in the same cycle as the next speculative shift -> GHR=0xA4 and repairs=1.
REQ-043 SHALL verify stall: stall=1 for 5 cycles with lookup_valid and update_valid high -> no table writes, GHR unchanged, statistics unchanged, pred_valid=0.
REQ-044 SHALL verify reset mid-sweep: assert reset at sweep entry 100 -> the sweep restarts at 0 and init_busy lasts a full 256 cycles.
REQ-045 SHALL verify collision: update writes idx 7 with 10 while a lookup reads idx 7 in the same cycle -> the prediction returns the old value 01, and the next lookup of idx 7 returns 10.

Source files
------------

// File: rtl/bpred_gshare.sv
`default_nettype none
// ============================================================================
// Module   : bpred_gshare
// Purpose  : Gshare branch direction predictor. A table of saturating
//            counters is indexed by PC[IDX_W+1:2] XOR global history. After
//            reset an INIT sweep sets every counter to weakly-not-taken and
//            then the predictor enters READY. The lookup-to-prediction
//            latency is one cycle. The GHR is updated speculatively with each
//            prediction and is repaired on a mispredict.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            stall             - freezes lookup, update, GHR and statistics
//            lookup_valid/pc   - prediction request
//            pred_*            - prediction result, plus the metadata that
//                                execute returns on update_*
//            update_*          - resolved branch (idx/ctr/hist echoed back)
//            init_busy         - table sweep in progress
//            debug_sel/out     - statistics readout
// Revision : 1.0 - initial release
// ============================================================================
module bpred_gshare #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  output logic              pred_valid,
  output logic              pred_dir,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              update_valid,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic [CTR_W-1:0]  update_ctr,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_dir,
  input  logic              update_miss,
  output logic              init_busy,
  input  logic [1:0]        debug_sel,
  output logic [31:0]       debug_out
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_WNT  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic                init_busy_q;
  logic [HIST_W-1:0]   ghr_q, ghr_d;
  logic                pred_valid_q, pred_dir_q;
  logic [IDX_W-1:0]    pred_idx_q;
  logic [CTR_W-1:0]    pred_ctr_q;
  logic [HIST_W-1:0]   pred_hist_q;
  logic [31:0]         st_lookups_q, st_updates_q, st_misses_q, st_repairs_q;

  logic [CTR_W-1:0]    table_q [DEPTH];

  logic                ready;
  logic                lookup_acc;
  logic                update_acc;
  logic                repair;
  logic [IDX_W-1:0]    lookup_idx;
  logic [CTR_W-1:0]    lookup_rd;
  logic [CTR_W-1:0]    upd_ctr_d;
  logic                tbl_we;
  logic [IDX_W-1:0]    tbl_wa;
  logic [CTR_W-1:0]    tbl_wd;
  logic                unused_pc_bits;

  assign ready      = (state_q == ST_READY);
  assign lookup_acc = ready & lookup_valid & ~stall;
  assign update_acc = ready & update_valid & ~stall;
  assign repair     = update_acc & update_miss;

  // History occupies the low bits of the index; upper index bits see PC only.
  assign lookup_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign lookup_rd  = table_q[lookup_idx];
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

  always_comb begin
    upd_ctr_d = update_ctr;
    if (update_dir) begin
      if (update_ctr != CTR_MAX) upd_ctr_d = update_ctr + 1'b1;
    end else begin
      if (update_ctr != '0) upd_ctr_d = update_ctr - 1'b1;
    end
  end

  // Shift-by-one-and-insert form works for every HIST_W, including 1.
  // Repair wins over the speculative shift of the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (repair) begin
      ghr_d = (update_hist << 1) | HIST_W'(update_dir);
    end else if (ready && pred_valid_q && !stall) begin
      ghr_d = (ghr_q << 1) | HIST_W'(pred_dir_q);
    end
  end

  // Single write port: the INIT sweep owns it (ignoring stall), READY updates
  // use it otherwise.
  always_comb begin
    tbl_we = 1'b0;
    tbl_wa = update_idx;
    tbl_wd = upd_ctr_d;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        tbl_we = 1'b1;
        tbl_wa = ptr_q;
        tbl_wd = CTR_WNT;
      end else begin
        tbl_we = update_acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) table_q[tbl_wa] <= tbl_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      init_busy_q  <= 1'b1;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_dir_q   <= 1'b0;
      pred_idx_q   <= '0;
      pred_ctr_q   <= '0;
      pred_hist_q  <= '0;
      st_lookups_q <= '0;
      st_updates_q <= '0;
      st_misses_q  <= '0;
      st_repairs_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_READY;
          init_busy_q <= 1'b0;
        end
      endcase

      // Prediction outputs hold their last value when no lookup is accepted.
      pred_valid_q <= lookup_acc;
      if (lookup_acc) begin
        pred_idx_q  <= lookup_idx;
        pred_ctr_q  <= lookup_rd;
        pred_dir_q  <= lookup_rd[CTR_W-1];
        pred_hist_q <= ghr_q;
      end

      ghr_q <= ghr_d;

      if (lookup_acc)                 st_lookups_q <= st_lookups_q + 32'd1;
      if (update_acc)                 st_updates_q <= st_updates_q + 32'd1;
      if (update_acc && update_miss)  st_misses_q  <= st_misses_q + 32'd1;
      if (repair)                     st_repairs_q <= st_repairs_q + 32'd1;
    end
  end

  always_comb begin
    case (debug_sel)
      2'b00:   debug_out = st_lookups_q;
      2'b01:   debug_out = st_updates_q;
      2'b10:   debug_out = st_misses_q;
      default: debug_out = st_repairs_q;
    endcase
  end

  assign pred_valid = pred_valid_q;
  assign pred_dir   = pred_dir_q;
  assign pred_idx   = pred_idx_q;
  assign pred_ctr   = pred_ctr_q;
  assign pred_hist  = pred_hist_q;
  assign init_busy  = init_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bpred_gshare.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpred_gshare
// Purpose  : Self-checking bench for bpred_gshare. A behavioural model tracks
//            the table as an integer array, the GHR as an integer and the
//            statistics as four counters. Every output is compared after
//            each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpred_gshare;

  localparam int IDX_W  = 8;
  localparam int HIST_W = 8;
  localparam int CTR_W  = 2;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              lookup_valid;
  logic [31:0]       lookup_pc;
  logic              pred_valid;
  logic              pred_dir;
  logic [IDX_W-1:0]  pred_idx;
  logic [CTR_W-1:0]  pred_ctr;
  logic [HIST_W-1:0] pred_hist;
  logic              update_valid;
  logic [IDX_W-1:0]  update_idx;
  logic [CTR_W-1:0]  update_ctr;
  logic [HIST_W-1:0] update_hist;
  logic              update_dir;
  logic              update_miss;
  logic              init_busy;
  logic [1:0]        debug_sel;
  logic [31:0]       debug_out;

  bpred_gshare #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_dir     (pred_dir),
    .pred_idx     (pred_idx),
    .pred_ctr     (pred_ctr),
    .pred_hist    (pred_hist),
    .update_valid (update_valid),
    .update_idx   (update_idx),
    .update_ctr   (update_ctr),
    .update_hist  (update_hist),
    .update_dir   (update_dir),
    .update_miss  (update_miss),
    .init_busy    (init_busy),
    .debug_sel    (debug_sel),
    .debug_out    (debug_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_tbl [DEPTH];
  int          m_ghr;
  int          m_busy_left;
  bit          m_pv, m_pdir;
  int          m_pidx, m_pctr, m_phist;
  int unsigned m_st [4];   // lookups, updates, misses, repairs

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic model_edge();
    int idx, rd, nghr;
    if (reset) begin
      m_busy_left = DEPTH;
      m_ghr = 0;
      m_pv = 0; m_pdir = 0; m_pidx = 0; m_pctr = 0; m_phist = 0;
      for (int s = 0; s < 4; s++) m_st[s] = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      m_pv = 0;
      if (m_busy_left == 0)
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;   // weakly not taken
    end else if (stall) begin
      m_pv = 0;
    end else begin
      idx  = ((int'(lookup_pc) >> 2) ^ m_ghr) & (DEPTH - 1);
      rd   = m_tbl[idx];
      nghr = m_ghr;
      if (m_pv) nghr = (m_ghr * 2 + int'(m_pdir)) % 256;
      if (update_valid) begin
        if (update_dir) m_tbl[update_idx] = (update_ctr == 3) ? 3 : int'(update_ctr) + 1;
        else            m_tbl[update_idx] = (update_ctr == 0) ? 0 : int'(update_ctr) - 1;
        m_st[1]++;
        if (update_miss) begin
          m_st[2]++;
          m_st[3]++;
          nghr = (int'(update_hist) * 2 + int'(update_dir)) % 256;
        end
      end
      if (lookup_valid) begin
        m_st[0]++;
        m_pidx  = idx;
        m_pctr  = rd;
        m_pdir  = (rd >= 2);
        m_phist = m_ghr;
      end
      m_pv  = lookup_valid;
      m_ghr = nghr;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("init_busy",  {31'd0, init_busy},  (m_busy_left > 0) ? 32'd1 : 32'd0);
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
    chk("pred_dir",   {31'd0, pred_dir},   {31'd0, m_pdir});
    chk("pred_idx",   {24'd0, pred_idx},   m_pidx);
    chk("pred_ctr",   {30'd0, pred_ctr},   m_pctr);
    chk("pred_hist",  {24'd0, pred_hist},  m_phist);
    chk("debug_out",  debug_out,           m_st[debug_sel]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit lv, input logic [31:0] pc, input bit uv,
                       input int uidx, input int uctr, input int uhist,
                       input bit udir, input bit umiss, input bit st);
    lookup_valid = lv;
    lookup_pc    = pc;
    update_valid = uv;
    update_idx   = uidx[IDX_W-1:0];
    update_ctr   = uctr[CTR_W-1:0];
    update_hist  = uhist[HIST_W-1:0];
    update_dir   = udir;
    update_miss  = umiss;
    stall        = st;
    debug_sel    = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_random(input int stall_pct);
    drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
          $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 255),
          $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 99) < stall_pct));
  endtask

  task automatic busy_count(output int cnt);
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 300) begin
      drive_random(20);
      step();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    int seq [4];
    int c_idx, c_ctr, c_hist;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 3;

    // Reset and initial sweep
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;
    busy_count(cnt);
    chk("init_len", cnt, 256);

    // First lookup right after init
    drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("init_pv",  {31'd0, pred_valid}, 32'd1);
    chk("init_ctr", {30'd0, pred_ctr},   32'd1);
    chk("init_dir", {31'd0, pred_dir},   32'd0);

    // Collision: write idx 7 and read idx 7 in the same cycle (GHR is 0)
    drive(1, 32'h1C, 1, 7, 1, 0, 1, 0, 0);
    step();
    chk("coll_old", {30'd0, pred_ctr}, 32'd1);
    drive(1, 32'h1C, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("coll_idx", {24'd0, pred_idx}, 32'd7);
    chk("coll_new", {30'd0, pred_ctr}, 32'd2);

    // Saturation: pin GHR to all ones, then train pc 0x40 taken
    drive(0, 0, 1, 1, 1, 8'h7F, 1, 1, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("sat_ctr",  {30'd0, pred_ctr},  seq[k]);
      chk("sat_hist", {24'd0, pred_hist}, 32'hFF);
      c_idx = pred_idx; c_ctr = pred_ctr; c_hist = pred_hist;
      drive(0, 0, 1, c_idx, c_ctr, c_hist, 1, (pred_dir !== 1'b1), 0);
      step();
    end

    // Repair: train idx 0x33 strongly taken, set GHR=0xA5, predict, repair
    drive(0, 0, 1, 8'h33, 1, 0, 1, 0, 0);
    step();
    drive(0, 0, 1, 8'h33, 2, 0, 1, 0, 0);
    step();
    drive(0, 0, 1, 2, 1, 8'h52, 1, 1, 0);
    step();
    drive(1, 32'h258, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rep_dir",  {31'd0, pred_dir},  32'd1);
    chk("rep_hist", {24'd0, pred_hist}, 32'hA5);
    c_idx = pred_idx; c_ctr = pred_ctr;
    drive(0, 0, 1, c_idx, c_ctr, 8'h52, 0, 1, 0);
    debug_sel = 2'b11;
    step();
    drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rep_ghr", {24'd0, pred_hist}, 32'hA4);

    // Stall for 5 cycles with lookup and update requests present
    for (int k = 0; k < 5; k++) begin
      drive(1, $urandom, 1, $urandom_range(0, 255), $urandom_range(0, 3),
            $urandom_range(0, 255), 1, 1, 1);
      step();
      chk("stall_pv", {31'd0, pred_valid}, 32'd0);
    end

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      drive_random(12);
      step();
    end

    // Reset in the middle of the sweep
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    repeat (100) begin
      drive_random(20);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy_count(cnt);
    chk("midsweep_len", cnt, 256);

    for (int k = 0; k < 100; k++) begin
      drive_random(12);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
